dm_access_unit: RTL and testbench



---
 rtl/dm_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_dm_access_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - word-organised data memory with sub-word load/store and sticky fault capture
//
// Purpose:
//   Responder behind the single-cycle MIPS load/store path. Loads are
//   combinational (latency 0) and sign/zero-extended per MemOp. Stores
//   commit at the rising edge through per-byte enables, so sub-word
//   stores merge into the existing word. Misaligned, out-of-range and
//   illegal-MemOp requests raise fault, are blocked, and the first one is
//   latched into a sticky error register for the exception logic.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset (clears array and error state)
//   MemWrite      store request this cycle
//   MemRead       load request this cycle
//   MemOp[2:0]    000 word, 001 half signed, 010 half unsigned,
//                 011 byte signed, 100 byte unsigned, 101-111 illegal
//   addr[31:0]    byte address
//   wdata[31:0]   store data; sub-words taken from the low bits
//   rdata[31:0]   extended load result, 0 when no legal load
//   fault         current request is misaligned / out of range / illegal
//   err_valid     sticky: a fault has been captured
//   err_addr      address of the first captured fault
//   err_is_store  first captured fault was a store
//   err_clr       clear the sticky error at the next edge

module dm_access_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  MemOp,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        err_valid,
    output logic [31:0] err_addr,
    output logic        err_is_store,
    input  logic        err_clr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [2:0] OP_WORD = 3'd0;
    localparam logic [2:0] OP_LH   = 3'd1;
    localparam logic [2:0] OP_LHU  = 3'd2;
    localparam logic [2:0] OP_LB   = 3'd3;
    localparam logic [2:0] OP_LBU  = 3'd4;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                  op_word;
    logic                  op_half;
    logic                  op_byte;
    logic                  op_illegal;
    logic                  out_of_range;
    logic                  misaligned;
    logic                  req;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;

    assign op_word    = (MemOp == OP_WORD);
    assign op_half    = (MemOp == OP_LH) || (MemOp == OP_LHU);
    assign op_byte    = (MemOp == OP_LB) || (MemOp == OP_LBU);
    assign op_illegal = !(op_word || op_half || op_byte);

    assign word_idx = addr[ADDR_WIDTH+1:2];
    assign lane     = addr[1:0];

    // Any set bit above the array's byte span means the access would alias.
    assign out_of_range = |addr[31:ADDR_WIDTH+2];

    // Byte accesses can never be misaligned.
    assign misaligned = (op_word && (lane != 2'b00)) ||
                        (op_half && lane[0]);

    assign req   = MemRead || MemWrite;
    assign fault = req && (misaligned || out_of_range || op_illegal);

    // ------------------------------------------------------------------
    // Load path (combinational, little-endian lanes)
    // ------------------------------------------------------------------
    logic [31:0] cur_word;
    logic [15:0] half_field;
    logic [7:0]  byte_field;
    logic [31:0] load_val;

    // For an out-of-range address the index still points somewhere in the
    // array; the result is discarded by the fault gate below.
    assign cur_word   = mem[word_idx];
    assign half_field = lane[1] ? cur_word[31:16] : cur_word[15:0];

    always_comb begin
        byte_field = cur_word[7:0];
        case (lane)
            2'd0: byte_field = cur_word[7:0];
            2'd1: byte_field = cur_word[15:8];
            2'd2: byte_field = cur_word[23:16];
            2'd3: byte_field = cur_word[31:24];
            default: byte_field = cur_word[7:0];
        endcase
    end

    always_comb begin
        load_val = '0;
        case (MemOp)
            OP_WORD: load_val = cur_word;
            OP_LH:   load_val = {{16{half_field[15]}}, half_field};
            OP_LHU:  load_val = {16'h0000, half_field};
            OP_LB:   load_val = {{24{byte_field[7]}}, byte_field};
            OP_LBU:  load_val = {24'h000000, byte_field};
            default: load_val = '0;
        endcase
    end

    // Reading during a store cycle returns the pre-store word because the
    // array only changes at the edge.
    assign rdata = (MemRead && !fault) ? load_val : '0;

    // ------------------------------------------------------------------
    // Store path: replicate the sub-word across all lanes and let the byte
    // enables pick the addressed ones.
    // ------------------------------------------------------------------
    logic [3:0]  byte_en;
    logic [31:0] wr_lanes;
    logic        do_store;

    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = wdata;
        if (op_word) begin
            byte_en  = 4'b1111;
            wr_lanes = wdata;
        end else if (op_half) begin
            byte_en  = lane[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{wdata[15:0]}};
        end else if (op_byte) begin
            byte_en  = 4'b0001 << lane;
            wr_lanes = {4{wdata[7:0]}};
        end
    end

    assign do_store = MemWrite && !fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky error capture. A fault in the same cycle as err_clr is still
    // captured, so capture is checked first and clear only applies when
    // nothing new is being recorded.
    // ------------------------------------------------------------------
    logic capture;

    assign capture = fault && (err_clr || !err_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid    <= 1'b0;
            err_addr     <= '0;
            err_is_store <= 1'b0;
        end else if (capture) begin
            err_valid    <= 1'b1;
            err_addr     <= addr;
            err_is_store <= MemWrite;
        end else if (err_clr) begin
            err_valid    <= 1'b0;
            err_addr     <= '0;
            err_is_store <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// tb/tb_dm_access_unit.sv - scoreboard bench for dm_access_unit against a byte-array memory model

module tb_dm_access_unit;

    localparam int AW     = 10;
    localparam int NBYTES = 4 << AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [2:0]  MemOp = 3'd0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        fault;
    logic        err_valid;
    logic [31:0] err_addr;
    logic        err_is_store;
    logic        err_clr = 1'b0;

    dm_access_unit #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .MemOp        (MemOp),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .fault        (fault),
        .err_valid    (err_valid),
        .err_addr     (err_addr),
        .err_is_store (err_is_store),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: flat little-endian byte memory plus error record
    // ------------------------------------------------------------------
    logic [7:0]  mm [NBYTES];
    logic        m_valid;
    logic [31:0] m_addr;
    logic        m_store;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        fault;
        logic        err_valid;
        logic [31:0] err_addr;
        logic        err_is_store;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic int m_size(input logic [2:0] op);
        case (op)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic bit m_fault(input bit w, input bit r, input logic [2:0] op,
                                   input logic [31:0] a);
        int sz = m_size(op);
        if (!(w || r)) return 1'b0;
        if (sz == 0) return 1'b1;
        if (a >= NBYTES) return 1'b1;
        if ((a % sz) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a);
        int sz = m_size(op);
        longint unsigned v = 0;
        for (int k = 0; k < sz; k++) v |= longint'(mm[a + k]) << (8 * k);
        if ((op == 3'd1 || op == 3'd3) && v[8*sz-1])
            v |= ~((64'd1 << (8 * sz)) - 1);
        return v[31:0];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NBYTES; i++) mm[i] = 8'h00;
        m_valid = 1'b0;
        m_addr  = '0;
        m_store = 1'b0;
    endtask

    // One request cycle: drive, predict from the model's pre-edge state,
    // then advance the model to what the coming edge commits.
    task automatic cycle(input bit w, input bit r, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d, input bit clr,
                         input string nm, input bit use_const = 1'b0,
                         input logic [31:0] const_rd = '0);
        exp_t e;
        bit   f;
        @(posedge clk);
        #1;
        MemWrite = w; MemRead = r; MemOp = op; addr = a; wdata = d; err_clr = clr;
        f = m_fault(w, r, op, a);
        e.name         = nm;
        e.fault        = f;
        e.rdata        = (r && !f) ? m_load(op, a) : 32'h0;
        if (use_const) e.rdata = const_rd;
        e.err_valid    = m_valid;
        e.err_addr     = m_addr;
        e.err_is_store = m_store;
        sb_q.push_back(e);
        if (w && !f) begin
            for (int k = 0; k < m_size(op); k++) mm[a + k] = d[8*k +: 8];
        end
        if (f && (clr || !m_valid)) begin
            m_valid = 1'b1; m_addr = a; m_store = w;
        end else if (clr) begin
            m_valid = 1'b0; m_addr = '0; m_store = 1'b0;
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        MemWrite = 0; MemRead = 0; MemOp = 0; addr = 0; wdata = 0; err_clr = 0;
    endtask

    // Hold reset across one edge, optionally with a store pending that must be dropped.
    task automatic do_reset(input bit w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        MemWrite = w; MemRead = 0; MemOp = 3'd0; addr = a; wdata = d; err_clr = 0;
        m_reset();
        e.name = "reset"; e.rdata = 32'h0; e.fault = m_fault(w, 1'b0, 3'd0, a);
        e.err_valid = 1'b0; e.err_addr = 32'h0; e.err_is_store = 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        MemWrite = 0; MemRead = 0; MemOp = 0; addr = 0; wdata = 0;
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares on the falling edge, away from the active edge
    // ------------------------------------------------------------------
    task automatic cmp32(input string nm, input string fld, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h t=%0t", nm, fld, got, want, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp32(e.name, "rdata",        rdata,               e.rdata);
                cmp32(e.name, "fault",        {31'b0, fault},      {31'b0, e.fault});
                cmp32(e.name, "err_valid",    {31'b0, err_valid},  {31'b0, e.err_valid});
                cmp32(e.name, "err_addr",     err_addr,            e.err_addr);
                cmp32(e.name, "err_is_store", {31'b0, err_is_store}, {31'b0, e.err_is_store});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        m_reset();
        do_reset(1'b0, 32'h0, 32'h0);

        for (int i = 0; i < (1 << AW); i++)
            cycle(0, 1, 3'd0, 32'(i * 4), 0, 0, "reset_read", 1'b1, 32'h0);

        cycle(1, 0, 3'd0, 32'h10, 32'h8899AABB, 0, "sw10");
        cycle(0, 1, 3'd3, 32'h10, 0, 0, "lb10",  1'b1, 32'hFFFFFFBB);
        cycle(0, 1, 3'd4, 32'h13, 0, 0, "lbu13", 1'b1, 32'h00000088);
        cycle(0, 1, 3'd1, 32'h12, 0, 0, "lh12",  1'b1, 32'hFFFF8899);
        cycle(0, 1, 3'd2, 32'h10, 0, 0, "lhu10", 1'b1, 32'h0000AABB);

        cycle(1, 0, 3'd0, 32'h20, 32'h11223344, 0, "sw20");
        cycle(1, 0, 3'd4, 32'h21, 32'h000000EE, 0, "sb21");
        cycle(0, 1, 3'd0, 32'h20, 0, 0, "lw20_sb", 1'b1, 32'h1122EE44);
        cycle(1, 0, 3'd2, 32'h22, 32'h0000CAFE, 0, "sh22");
        cycle(0, 1, 3'd0, 32'h20, 0, 0, "lw20_sh", 1'b1, 32'hCAFEEE44);

        cycle(1, 0, 3'd0, 32'h22, 32'hDEADBEEF, 0, "sw22_mis");
        cycle(0, 1, 3'd0, 32'h20, 0, 0, "lw20_kept", 1'b1, 32'hCAFEEE44);
        cycle(0, 1, 3'd0, 32'h31, 0, 0, "lw31_mis");
        cycle(0, 0, 3'd0, 32'h0, 0, 0, "after_lw31");

        cycle(0, 1, 3'd0, 32'h00001000, 0, 0, "lw_oor", 1'b1, 32'h0);
        cycle(0, 1, 3'd1, 32'h05, 0, 1, "clr_lh05", 1'b1, 32'h0);
        cycle(0, 0, 3'd0, 32'h0, 0, 0, "after_clr");
        cycle(0, 0, 3'd0, 32'h0, 0, 1, "plain_clr");
        cycle(0, 1, 3'd5, 32'h40, 0, 0, "illegal_op", 1'b1, 32'h0);
        cycle(0, 0, 3'd7, 32'h3, 0, 0, "no_req");

        cycle(1, 1, 3'd0, 32'h40, 32'h12345678, 0, "sw_rd40", 1'b1, 32'h0);
        cycle(0, 1, 3'd0, 32'h40, 0, 0, "lw40", 1'b1, 32'h12345678);
        cycle(1, 0, 3'd0, 32'h44, 32'hA5A5A5A5, 0, "sw44");
        do_reset(1'b1, 32'h48, 32'hDEADBEEF);
        cycle(0, 1, 3'd0, 32'h40, 0, 0, "lw40_rst", 1'b1, 32'h0);
        cycle(0, 1, 3'd0, 32'h44, 0, 0, "lw44_rst", 1'b1, 32'h0);
        cycle(0, 1, 3'd0, 32'h48, 0, 0, "lw48_rst", 1'b1, 32'h0);
        cycle(0, 1, 3'd0, 32'h00000FFC, 0, 0, "lw_top", 1'b1, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            op = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 31) == 0) a = 32'h00000FFC + 32'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, a, $urandom,
                  ($urandom_range(0, 9) == 0), "rand");
        end

        idle();
        @(negedge clk);
        #1;
        cmp32("drain", "queue_left", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
